// File: rtl/usb_pkg.sv
// Shared sizing constants and store-size encoding for the USB transmit data path.
package usb_pkg;

    localparam int DEPTH = 64;
    localparam int PTR_W = 6;
    localparam int CNT_W = 7;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } store_size_e;

    // Bytes carried by a host write; the reserved encoding carries none.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_bytes = 3'd1;
            SIZE_HALF: size_bytes = 3'd2;
            SIZE_WORD: size_bytes = 3'd4;
            default:   size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and sticky error control for the TX byte FIFO.
// Latency: decisions are combinational, state updates on the next clk edge.
// Backpressure: none; writes without room and pops while empty are dropped and flagged.
module fifo_ptr_ctrl
    import usb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push_req,
    input  logic [1:0]       push_size,
    input  logic             pop_req,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count,
    output logic             push_ok,
    output logic             pop_ok,
    output logic             overrun_error,
    output logic             underrun_error
);

    logic [CNT_W-1:0] push_n;
    logic [CNT_W-1:0] free_space;
    logic [CNT_W-1:0] count_nxt;

    assign push_n     = CNT_W'(size_bytes(push_size));
    assign free_space = CNT_W'(DEPTH) - count;

    // Free space is judged on the pre-pop count, so a same-cycle pop never makes room.
    always_comb begin
        push_ok = 1'b0;
        pop_ok  = 1'b0;
        if (!clear) begin
            push_ok = push_req && (push_n != '0) && (free_space >= push_n);
            pop_ok  = pop_req && (count != '0);
        end
        count_nxt = count + (push_ok ? push_n : '0) - (pop_ok ? CNT_W'(1) : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            overrun_error  <= 1'b0;
            underrun_error <= 1'b0;
        end else if (clear) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            overrun_error  <= 1'b0;
            underrun_error <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(push_n);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt;
            if (push_req && !push_ok) begin
                overrun_error <= 1'b1;
            end
            if (pop_req && !pop_ok) begin
                underrun_error <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/usb_tx_data_fifo.sv
// Host-to-transmitter byte FIFO accepting 1/2/4-byte writes and single-byte pops.
// Latency: written byte visible one cycle after the store edge; head is first-word-fall-through.
// Backpressure: none; overflowing writes and empty pops are discarded and raise sticky flags.
module usb_tx_data_fifo #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        store_tx_data,
    input  logic [1:0]  store_size,
    input  logic [31:0] tx_data_in,
    input  logic        clear,
    input  logic        get_tx_packet_data,
    output logic [7:0]  tx_packet_data,
    output logic [6:0]  buffer_occupancy,
    output logic        overrun_error,
    output logic        underrun_error
);

    import usb_pkg::*;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;
    logic [3:0]       byte_en;

    fifo_ptr_ctrl u_ctrl (
        .clk            (clk),
        .rst            (n_rst),
        .clear          (clear),
        .push_req       (store_tx_data),
        .push_size      (store_size),
        .pop_req        (get_tx_packet_data),
        .wr_ptr         (wr_ptr),
        .rd_ptr         (rd_ptr),
        .count          (count),
        .push_ok        (push_ok),
        .pop_ok         (pop_ok),
        .overrun_error  (overrun_error),
        .underrun_error (underrun_error)
    );

    always_comb begin
        byte_en = 4'b0000;
        case (store_size)
            SIZE_BYTE: byte_en = 4'b0001;
            SIZE_HALF: byte_en = 4'b0011;
            SIZE_WORD: byte_en = 4'b1111;
            default:   byte_en = 4'b0000;
        endcase
    end

    // Storage is not reset; the zero count masks stale contents.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[wr_ptr + PTR_W'(i)] <= tx_data_in[8*i +: 8];
                end
            end
        end
    end

    assign tx_packet_data   = (count != '0) ? mem[rd_ptr] : 8'h00;
    assign buffer_occupancy = count;

endmodule

// File: tb/tb_usb_tx_data_fifo.sv
// Self-checking bench for usb_tx_data_fifo: vector table plus byte scoreboard.
module tb_usb_tx_data_fifo;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        store_tx_data;
    logic [1:0]  store_size;
    logic [31:0] tx_data_in;
    logic        clear;
    logic        get_tx_packet_data;
    logic [7:0]  tx_packet_data;
    logic [6:0]  buffer_occupancy;
    logic        overrun_error;
    logic        underrun_error;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb[$];
    logic       m_ovr;
    logic       m_und;

    typedef struct {
        logic        st;
        logic [1:0]  sz;
        logic [31:0] d;
        logic        pp;
        logic        cl;
        int          occ;
        logic [7:0]  head;
        logic        ovr;
        logic        und;
    } vec_t;

    vec_t vt[11];

    usb_tx_data_fifo #(.DEPTH(64)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .store_tx_data      (store_tx_data),
        .store_size         (store_size),
        .tx_data_in         (tx_data_in),
        .clear              (clear),
        .get_tx_packet_data (get_tx_packet_data),
        .tx_packet_data     (tx_packet_data),
        .buffer_occupancy   (buffer_occupancy),
        .overrun_error      (overrun_error),
        .underrun_error     (underrun_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_occ"}, 32'(buffer_occupancy), 32'(sb.size()));
        chk({tag, "_head"}, 32'(tx_packet_data), (sb.size() > 0) ? 32'(sb[0]) : 32'h0);
        chk({tag, "_ovr"}, 32'(overrun_error), 32'(m_ovr));
        chk({tag, "_und"}, 32'(underrun_error), 32'(m_und));
    endtask

    // One clock of stimulus, called just after a falling edge.
    task automatic cyc(input logic st, input logic [1:0] sz, input logic [31:0] d,
                       input logic pp, input logic cl);
        int  cnt0;
        int  n;
        bit  pu;
        bit  po;
        store_tx_data      = st;
        store_size         = sz;
        tx_data_in         = d;
        get_tx_packet_data = pp;
        clear              = cl;
        cnt0 = sb.size();
        n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        po   = pp && !cl && (cnt0 > 0);
        pu   = st && !cl && (n != 0) && ((64 - cnt0) >= n);
        #1;
        if (po) chk("pop_byte", 32'(tx_packet_data), 32'(sb[0]));
        @(posedge clk);
        if (cl) begin
            sb.delete();
            m_ovr = 1'b0;
            m_und = 1'b0;
        end else begin
            if (po) void'(sb.pop_front());
            if (pu) for (int i = 0; i < n; i++) sb.push_back(d[8*i +: 8]);
            if (st && !pu) m_ovr = 1'b1;
            if (pp && !po) m_und = 1'b1;
        end
        @(negedge clk);
        store_tx_data      = 1'b0;
        get_tx_packet_data = 1'b0;
        clear              = 1'b0;
        check_model("cyc");
    endtask

    task automatic fill62(input logic [7:0] seed);
        logic [7:0] b;
        b = seed;
        for (int i = 0; i < 15; i++) begin
            cyc(1'b1, 2'd2, {b + 8'd3, b + 8'd2, b + 8'd1, b}, 1'b0, 1'b0);
            b = b + 8'd4;
        end
        cyc(1'b1, 2'd1, {16'h0, b + 8'd1, b}, 1'b0, 1'b0);
    endtask

    initial begin
        n_rst = 1'b1;
        store_tx_data = 1'b0;
        store_size = 2'd0;
        tx_data_in = '0;
        clear = 1'b0;
        get_tx_packet_data = 1'b0;
        m_ovr = 1'b0;
        m_und = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_occ", 32'(buffer_occupancy), 32'd0);
        chk("rst_head", 32'(tx_packet_data), 32'h0);
        chk("rst_ovr", 32'(overrun_error), 32'd0);
        chk("rst_und", 32'(underrun_error), 32'd0);
        n_rst = 1'b0;
        @(negedge clk);

        vt[0]  = '{1'b1, 2'd2, 32'h44332211, 1'b0, 1'b0, 4, 8'h11, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 3, 8'h22, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 2, 8'h33, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 1, 8'h44, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b1};
        vt[6]  = '{1'b1, 2'd0, 32'h0000005A, 1'b1, 1'b0, 1, 8'h5A, 1'b0, 1'b1};
        vt[7]  = '{1'b1, 2'd3, 32'h12345678, 1'b0, 1'b0, 1, 8'h5A, 1'b1, 1'b1};
        vt[8]  = '{1'b0, 2'd0, 32'h0,        1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0};
        vt[9]  = '{1'b1, 2'd1, 32'h0000BEEF, 1'b0, 1'b0, 2, 8'hEF, 1'b0, 1'b0};
        vt[10] = '{1'b1, 2'd2, 32'h01020304, 1'b1, 1'b1, 0, 8'h00, 1'b0, 1'b0};

        for (int k = 0; k < 11; k++) begin
            cyc(vt[k].st, vt[k].sz, vt[k].d, vt[k].pp, vt[k].cl);
            chk($sformatf("vec%0d_occ", k), 32'(buffer_occupancy), 32'(vt[k].occ));
            chk($sformatf("vec%0d_head", k), 32'(tx_packet_data), 32'(vt[k].head));
            chk($sformatf("vec%0d_ovr", k), 32'(overrun_error), 32'(vt[k].ovr));
            chk($sformatf("vec%0d_und", k), 32'(underrun_error), 32'(vt[k].und));
        end

        // Overrun at 62 bytes, then fill to 64, then push+pop while full.
        fill62(8'h80);
        chk("fill_occ62", 32'(buffer_occupancy), 32'd62);
        cyc(1'b1, 2'd2, 32'hCAFEF00D, 1'b0, 1'b0);
        chk("word_rej_occ", 32'(buffer_occupancy), 32'd62);
        chk("word_rej_ovr", 32'(overrun_error), 32'd1);
        cyc(1'b1, 2'd1, 32'h0000C1C0, 1'b0, 1'b0);
        chk("half_ok_occ", 32'(buffer_occupancy), 32'd64);
        cyc(1'b1, 2'd0, 32'h000000EE, 1'b1, 1'b0);
        chk("full_pp_occ", 32'(buffer_occupancy), 32'd63);
        chk("full_pp_ovr", 32'(overrun_error), 32'd1);
        for (int i = 0; i < 63; i++) cyc(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
        chk("drain_occ", 32'(buffer_occupancy), 32'd0);

        // Pointer wrap: park both pointers at 62, then write a word across the boundary.
        cyc(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
        fill62(8'h10);
        for (int i = 0; i < 62; i++) cyc(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 2'd2, 32'hDDCCBBAA, 1'b0, 1'b0);
        chk("wrap_occ", 32'(buffer_occupancy), 32'd4);
        chk("wrap_h0", 32'(tx_packet_data), 32'hAA);
        cyc(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
        chk("wrap_h1", 32'(tx_packet_data), 32'hBB);
        cyc(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
        chk("wrap_h2", 32'(tx_packet_data), 32'hCC);
        cyc(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
        chk("wrap_h3", 32'(tx_packet_data), 32'hDD);
        cyc(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
        chk("wrap_end_occ", 32'(buffer_occupancy), 32'd0);

        // Clear beats a simultaneous store and pop at 10 bytes with flags raised.
        cyc(1'b1, 2'd2, 32'h03020100, 1'b0, 1'b0);
        cyc(1'b1, 2'd2, 32'h07060504, 1'b0, 1'b0);
        cyc(1'b1, 2'd1, 32'h00000908, 1'b0, 1'b0);
        cyc(1'b1, 2'd3, 32'h0, 1'b0, 1'b0);
        chk("pre_clr_occ", 32'(buffer_occupancy), 32'd10);
        chk("pre_clr_ovr", 32'(overrun_error), 32'd1);
        cyc(1'b1, 2'd2, 32'hFFEEDDCC, 1'b1, 1'b1);
        chk("clr_occ", 32'(buffer_occupancy), 32'd0);
        chk("clr_ovr", 32'(overrun_error), 32'd0);
        chk("clr_und", 32'(underrun_error), 32'd0);

        // Asynchronous reset in the middle of a pop.
        cyc(1'b1, 2'd2, 32'h0A0B0C0D, 1'b0, 1'b0);
        get_tx_packet_data = 1'b1;
        #2;
        n_rst = 1'b1;
        #1;
        chk("arst_occ", 32'(buffer_occupancy), 32'd0);
        chk("arst_head", 32'(tx_packet_data), 32'h0);
        get_tx_packet_data = 1'b0;
        sb.delete();
        m_ovr = 1'b0;
        m_und = 1'b0;
        @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        check_model("post_arst");
        cyc(1'b1, 2'd0, 32'h00000077, 1'b0, 1'b0);
        chk("post_arst_head", 32'(tx_packet_data), 32'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
